// File: rtl/rob_dispatch_alloc.sv
// ROB tag allocator for the dispatch stage: hands out tags 1..2^ROB_SEL-1 in order,
// tracks free entries against commits, and registers the dispatch strobe and payload.
module rob_dispatch_alloc #(
  parameter int ROB_SEL  = 6,
  parameter int ADDR_LEN = 32,
  parameter int REG_SEL  = 5
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                inst_valid_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic [REG_SEL-1:0]  dst_i,
  input  logic                dstvalid_i,
  output logic                ready_o,
  input  logic                comnum_i,
  input  logic                flush_i,
  input  logic [ROB_SEL-1:0]  flush_ptr_i,
  output logic                dp1_o,
  output logic [ROB_SEL-1:0]  dp1_addr_o,
  output logic [ADDR_LEN-1:0] pc_dp1_o,
  output logic [REG_SEL-1:0]  dst_dp1_o,
  output logic                dstvalid_dp1_o,
  output logic [ROB_SEL-1:0]  free_cnt_o
);

  localparam logic [ROB_SEL-1:0] TAG_MAX = '1;
  localparam logic [ROB_SEL-1:0] TAG_ONE = ROB_SEL'(1);

  logic [ROB_SEL-1:0]  r_alloc_ptr;
  logic [ROB_SEL-1:0]  r_free_cnt;
  logic                r_dp1;
  logic [ROB_SEL-1:0]  r_dp1_addr;
  logic [ADDR_LEN-1:0] r_pc;
  logic [REG_SEL-1:0]  r_dst;
  logic                r_dstvalid;

  logic                w_ready;
  logic                w_accept;
  logic                w_free_full;
  logic [ROB_SEL-1:0]  w_alloc_ptr_nxt;
  logic [ROB_SEL-1:0]  w_free_cnt_nxt;

  // A flush squashes this cycle's allocation, so it also withdraws ready.
  assign w_ready     = (r_free_cnt != '0) & ~flush_i;
  assign w_accept    = inst_valid_i & w_ready;
  assign w_free_full = (r_free_cnt == TAG_MAX);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_alloc_ptr_nxt = r_alloc_ptr;
    w_free_cnt_nxt  = r_free_cnt;
    if (flush_i) begin
      w_alloc_ptr_nxt = (flush_ptr_i == '0) ? TAG_ONE : flush_ptr_i;
      w_free_cnt_nxt  = TAG_MAX;
    end else begin
      if (w_accept) begin
        w_alloc_ptr_nxt = (r_alloc_ptr == TAG_MAX) ? TAG_ONE : r_alloc_ptr + TAG_ONE;
      end
      // A commit against an empty ROB is spurious and must not overflow the count.
      unique case ({w_accept, comnum_i})
        2'b10:   w_free_cnt_nxt = r_free_cnt - TAG_ONE;
        2'b01:   w_free_cnt_nxt = w_free_full ? r_free_cnt : r_free_cnt + TAG_ONE;
        default: w_free_cnt_nxt = r_free_cnt;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_alloc_ptr <= TAG_ONE;
      r_free_cnt  <= TAG_MAX;
      r_dp1       <= 1'b0;
      r_dp1_addr  <= '0;
      r_pc        <= '0;
      r_dst       <= '0;
      r_dstvalid  <= 1'b0;
    end else begin
      r_alloc_ptr <= w_alloc_ptr_nxt;
      r_free_cnt  <= w_free_cnt_nxt;
      r_dp1       <= w_accept;
      if (w_accept) begin
        r_dp1_addr <= r_alloc_ptr;
        r_pc       <= pc_i;
        r_dst      <= dst_i;
        r_dstvalid <= dstvalid_i;
      end
    end
  end

  assign ready_o        = w_ready;
  assign dp1_o          = r_dp1;
  assign dp1_addr_o     = r_dp1_addr;
  assign pc_dp1_o       = r_pc;
  assign dst_dp1_o      = r_dst;
  assign dstvalid_dp1_o = r_dstvalid;
  assign free_cnt_o     = r_free_cnt;

endmodule

// File: tb/tb_rob_dispatch_alloc.sv
// Self-checking bench for rob_dispatch_alloc: directed corner cases plus random traffic,
// with expected dispatches queued by a reference model and checked by a separate monitor.
module tb_rob_dispatch_alloc;

  localparam int ROB_SEL  = 6;
  localparam int ADDR_LEN = 32;
  localparam int REG_SEL  = 5;
  localparam int NTAGS    = (1 << ROB_SEL) - 1;

  logic                clk_i = 1'b0;
  logic                reset_i = 1'b0;
  logic                inst_valid_i = 1'b0;
  logic [ADDR_LEN-1:0] pc_i = '0;
  logic [REG_SEL-1:0]  dst_i = '0;
  logic                dstvalid_i = 1'b0;
  logic                ready_o;
  logic                comnum_i = 1'b0;
  logic                flush_i = 1'b0;
  logic [ROB_SEL-1:0]  flush_ptr_i = '0;
  logic                dp1_o;
  logic [ROB_SEL-1:0]  dp1_addr_o;
  logic [ADDR_LEN-1:0] pc_dp1_o;
  logic [REG_SEL-1:0]  dst_dp1_o;
  logic                dstvalid_dp1_o;
  logic [ROB_SEL-1:0]  free_cnt_o;

  rob_dispatch_alloc #(.ROB_SEL(ROB_SEL), .ADDR_LEN(ADDR_LEN), .REG_SEL(REG_SEL)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .inst_valid_i(inst_valid_i), .pc_i(pc_i),
    .dst_i(dst_i), .dstvalid_i(dstvalid_i), .ready_o(ready_o), .comnum_i(comnum_i),
    .flush_i(flush_i), .flush_ptr_i(flush_ptr_i), .dp1_o(dp1_o), .dp1_addr_o(dp1_addr_o),
    .pc_dp1_o(pc_dp1_o), .dst_dp1_o(dst_dp1_o), .dstvalid_dp1_o(dstvalid_dp1_o),
    .free_cnt_o(free_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int                  tag;
    logic [ADDR_LEN-1:0] pc;
    logic [REG_SEL-1:0]  dst;
    logic                dv;
    int                  cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   m_free;
  int   m_next_tag;
  int   n_disp = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented dispatch against the oldest expected one.
  always @(negedge clk_i) begin
    if (reset_i) begin
      if (dp1_o) begin
        if (q.size() == 0) begin
          check("unexpected_dispatch", 64'(dp1_o), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          n_disp++;
          check("disp_cycle", 64'(cyc), 64'(e.cyc));
          check("disp_tag", 64'(dp1_addr_o), 64'(e.tag));
          check("disp_pc", 64'(pc_dp1_o), 64'(e.pc));
          check("disp_dst", 64'(dst_dp1_o), 64'(e.dst));
          check("disp_dstvalid", 64'(dstvalid_dp1_o), 64'(e.dv));
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        check("missing_dispatch", 64'(dp1_o), 64'd1);
        void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [ADDR_LEN-1:0] pc, input logic [REG_SEL-1:0] dst,
                      input logic dv, input logic cm, input logic fl, input logic [ROB_SEL-1:0] fp);
    bit m_ready, m_acc;
    exp_t e;
    inst_valid_i = v; pc_i = pc; dst_i = dst; dstvalid_i = dv;
    comnum_i = cm; flush_i = fl; flush_ptr_i = fp;
    #3;
    m_ready = (m_free != 0) && !fl;
    m_acc   = v && m_ready;
    check("ready", 64'(ready_o), 64'(m_ready));
    if (m_acc) begin
      e.tag = m_next_tag; e.pc = pc; e.dst = dst; e.dv = dv; e.cyc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk_i);
    #1;
    if (fl) begin
      m_next_tag = (fp == 0) ? 1 : int'(fp);
      m_free     = NTAGS;
    end else begin
      m_free = m_free - int'(m_acc) + int'(cm);
      if (m_free > NTAGS) m_free = NTAGS;
      if (m_acc) m_next_tag = (m_next_tag == NTAGS) ? 1 : m_next_tag + 1;
    end
    check("free_cnt", 64'(free_cnt_o), 64'(m_free));
    inst_valid_i = 1'b0; comnum_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic acc(input logic [ADDR_LEN-1:0] pc);
    step(1'b1, pc, REG_SEL'($urandom), 1'($urandom), 1'b0, 1'b0, '0);
  endtask

  // Asserts reset mid-cycle, checks the held values, releases after the next edge.
  task automatic do_reset();
    reset_i = 1'b0;
    q.delete();
    m_free = NTAGS;
    m_next_tag = 1;
    #1;
    check("rst_dp1", 64'(dp1_o), 64'd0);
    check("rst_addr", 64'(dp1_addr_o), 64'd0);
    check("rst_pc", 64'(pc_dp1_o), 64'd0);
    check("rst_dst", 64'(dst_dp1_o), 64'd0);
    check("rst_dv", 64'(dstvalid_dp1_o), 64'd0);
    check("rst_free", 64'(free_cnt_o), 64'(NTAGS));
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    m_free = NTAGS;
    m_next_tag = 1;
    @(posedge clk_i);
    #1;
    do_reset();

    // Three back-to-back accepts after reset: tags 1,2,3, free count 60.
    acc(32'h100);
    acc(32'h104);
    acc(32'h108);
    idle();
    check("free_after_3", 64'(free_cnt_o), 64'd60);

    // Fill every tag, stall a held instruction, then release it with one commit.
    do_reset();
    for (int i = 0; i < NTAGS; i++) acc(32'h1000 + 32'(4 * i));
    check("full_ready", 64'(ready_o), 64'd0);
    check("full_free", 64'(free_cnt_o), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hBEEF, 5'd7, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 32'hBEEF, 5'd7, 1'b1, 1'b1, 1'b0, '0);
    check("free_after_commit", 64'(free_cnt_o), 64'd1);
    step(1'b1, 32'hBEEF, 5'd7, 1'b1, 1'b0, 1'b0, '0);
    check("wrap_tag", 64'(dp1_addr_o), 64'd1);

    // Accept and commit together at free count 10.
    do_reset();
    for (int i = 0; i < NTAGS - 10; i++) acc(32'h2000 + 32'(4 * i));
    check("free_is_10", 64'(free_cnt_o), 64'd10);
    step(1'b1, 32'h3000, 5'd3, 1'b0, 1'b1, 1'b0, '0);
    check("acc_cm_free", 64'(free_cnt_o), 64'd10);
    check("acc_cm_dp1", 64'(dp1_o), 64'd1);

    // Commit with the ROB empty is ignored.
    do_reset();
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    check("empty_commit", 64'(free_cnt_o), 64'(NTAGS));

    // Flush beats a simultaneous instruction and commit.
    for (int i = 0; i < 5; i++) acc(32'h4000 + 32'(4 * i));
    step(1'b1, 32'h5000, 5'd1, 1'b1, 1'b1, 1'b1, 6'd17);
    check("flush_dp1", 64'(dp1_o), 64'd0);
    check("flush_free", 64'(free_cnt_o), 64'(NTAGS));
    acc(32'h5004);
    check("flush_tag", 64'(dp1_addr_o), 64'd17);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 6'd0);
    acc(32'h5008);
    check("flush0_tag", 64'(dp1_addr_o), 64'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 70), $urandom, REG_SEL'($urandom), 1'($urandom),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 3), ROB_SEL'($urandom));
    end
    idle();

    // Asynchronous reset while a dispatch strobe is showing.
    acc(32'h6000);
    check("pre_rst_dp1", 64'(dp1_o), 64'd1);
    #1;
    reset_i = 1'b0;
    #1;
    check("async_rst_dp1", 64'(dp1_o), 64'd0);
    do_reset();
    acc(32'h6004);
    check("post_rst_tag", 64'(dp1_addr_o), 64'd1);
    idle();
    idle();

    check("queue_drained", 64'(q.size()), 64'd0);
    check("dispatches_seen", 64'(n_disp > 100), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rob_dispatch_alloc.md
ROB_DISPATCH_ALLOC -- requirements
Module: rob_dispatch_alloc

Interface
REQ-001 The block SHALL have parameter ROB_SEL, default 6, meaning ROB tag width; usable tags are 1..2^ROB_SEL-1 and tag 0 is reserved.
REQ-002 The block SHALL have parameter ADDR_LEN, default 32, meaning instruction PC width.
REQ-003 The block SHALL have parameter REG_SEL, default 5, meaning logical register index width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk_i, input, 1, the sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_i, input, 1, asynchronous active-low reset (0 = reset).
REQ-007 The block SHALL have port inst_valid_i, input, 1, decoded instruction present.
REQ-008 The block SHALL have ports pc_i (ADDR_LEN), dst_i (REG_SEL) and dstvalid_i (1), all inputs, carrying the instruction payload.
REQ-009 The block SHALL have port ready_o, output, 1, meaning a ROB tag is available to accept an instruction this cycle.
REQ-010 The block SHALL have port comnum_i, input, 1, meaning one ROB entry committed this cycle and its tag is freed.
REQ-011 The block SHALL have ports flush_i (1) and flush_ptr_i (ROB_SEL), both inputs, meaning a pipeline flush with the restart tag (the current commit pointer).
REQ-012 The block SHALL have port dp1_o, output, 1, a registered dispatch strobe to the ROB.
REQ-013 The block SHALL have port dp1_addr_o, output, ROB_SEL, the allocated tag.
REQ-014 The block SHALL have ports pc_dp1_o, dst_dp1_o and dstvalid_dp1_o, outputs, registered copies of the payload.
REQ-015 The block SHALL have port free_cnt_o, output, ROB_SEL, the number of free tags.

Function
REQ-016 The block SHALL hold alloc_ptr (the next tag to allocate) and free_cnt (range 0..2^ROB_SEL-1) in registers.
REQ-017 ready_o SHALL be combinational: (free_cnt != 0) & ~flush_i.
REQ-018 accept SHALL equal inst_valid_i & ready_o; when inst_valid_i=1 and ready_o=0, the instruction is not consumed and upstream holds it.
REQ-019 On accept, the next cycle SHALL present dp1_o=1, dp1_addr_o=old alloc_ptr, and the captured pc/dst/dstvalid; otherwise dp1_o=0 and the payload outputs hold their last values.
REQ-020 Dispatch latency SHALL be exactly one cycle, with a throughput of one instruction per cycle.
REQ-021 On accept, alloc_ptr SHALL increment by 1, wrapping from 2^ROB_SEL-1 to 1 and never producing 0.
REQ-022 free_cnt_next SHALL equal free_cnt - accept + comnum_i; when both occur in the same cycle, free_cnt is unchanged.
REQ-023 When comnum_i=1 and free_cnt=2^ROB_SEL-1 (ROB empty), comnum_i SHALL be ignored and free_cnt SHALL not exceed its maximum.
REQ-024 When free_cnt=0, no allocation SHALL occur, and a simultaneous comnum_i takes free_cnt to 1 with ready_o rising the following cycle.
REQ-025 On flush_i, the next cycle SHALL have alloc_ptr=flush_ptr_i (0 mapped to 1), free_cnt=2^ROB_SEL-1 and dp1_o=0; no accept or comnum_i is counted in that cycle.
REQ-026 flush_i SHALL take priority over inst_valid_i and comnum_i.
REQ-027 free_cnt_o SHALL equal the free_cnt register.

Reset
REQ-028 While reset_i=0, outputs SHALL be held: alloc_ptr=1, free_cnt=2^ROB_SEL-1, dp1_o=0, dp1_addr_o=0, pc_dp1_o=0, dst_dp1_o=0, dstvalid_dp1_o=0.
REQ-029 Reset assertion SHALL take effect asynchronously, including mid-dispatch, discarding any pending dispatch strobe.
REQ-030 After reset_i deasserts, the first accepted instruction SHALL receive tag 1.

Verification
REQ-031 The bench SHALL cover reset then 3 back-to-back accepts with pc 0x100/0x104/0x108: dp1_addr_o=1,2,3 on consecutive cycles one cycle after each accept, and free_cnt_o=60.
REQ-032 The bench SHALL cover 63 accepts with no commits: ready_o=0 after the 63rd and free_cnt_o=0; then a 64th inst_valid_i is held and not dispatched until comnum_i pulses, after which it receives tag 1 (wrap skips 0).
REQ-033 The bench SHALL cover accept and comnum_i in the same cycle at free_cnt=10: free_cnt_o stays 10 and dp1_o=1.
REQ-034 The bench SHALL cover comnum_i with the ROB empty: free_cnt_o stays 63.
REQ-035 The bench SHALL cover flush_i with flush_ptr_i=17 while inst_valid_i=1 and comnum_i=1: the next cycle dp1_o=0 and free_cnt_o=63, and the next accept receives tag 17.
REQ-036 The bench SHALL cover reset_i asserted asynchronously between clock edges while dp1_o=1: dp1_o drops immediately and the following accept gets tag 1.
